wb_stage_pipelined: RTL and testbench

- Parametrised successor to the combinational write-back select.
- Holds the MEM/WB pipeline register with stall and flush control.
- Performs load alignment with sign or zero extension and selects among four result sources.
- Owns the architectural HI/LO registers and a retired-instruction counter.
- Sits between the data-memory stage and the register file and hazard unit.

---
 rtl/wb_stage_pipelined_if.sv | 61 ++++++
 rtl/wb_stage_pipelined.sv | 170 +++++++++++++++++
 tb/tb_wb_stage_pipelined.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_pipelined_if.sv
// ----------------------------------------------------------------------------
// wb_stage_pipelined_if
//   Bundles the memory-stage entry, the W-register control and the write-back
//   results of wb_stage_pipelined into one interface.
//
//   master : the upstream side (memory stage / hazard unit). It drives the
//            M-stage fields and i_StallW/i_FlushW and observes the W outputs.
//   slave  : the write-back stage itself.
//
//   M-stage fields : i_ValidM, i_RegWriteM, i_WriteRegM, i_ResultSrcM,
//                    i_HiLoSelM, i_LoadTypeM, i_LoadUnsignedM, i_HiLoWriteM,
//                    i_ALUOutM, i_ReadDataM, i_PCPlus4M, i_HiM, i_LoM
//   W control      : i_StallW (hold), i_FlushW (bubble, wins over stall)
//   W outputs      : o_ResultW, o_WriteRegW, o_RegWriteW, o_MisalignW,
//                    o_HiW, o_LoW, o_RetireCount
// ----------------------------------------------------------------------------
interface wb_stage_pipelined_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic                      i_ValidM;
    logic                      i_RegWriteM;
    logic [REG_ADDR_WIDTH-1:0] i_WriteRegM;
    logic [1:0]                i_ResultSrcM;
    logic                      i_HiLoSelM;
    logic [1:0]                i_LoadTypeM;
    logic                      i_LoadUnsignedM;
    logic                      i_HiLoWriteM;
    logic [DATA_WIDTH-1:0]     i_ALUOutM;
    logic [DATA_WIDTH-1:0]     i_ReadDataM;
    logic [DATA_WIDTH-1:0]     i_PCPlus4M;
    logic [DATA_WIDTH-1:0]     i_HiM;
    logic [DATA_WIDTH-1:0]     i_LoM;
    logic                      i_StallW;
    logic                      i_FlushW;

    logic [DATA_WIDTH-1:0]     o_ResultW;
    logic [REG_ADDR_WIDTH-1:0] o_WriteRegW;
    logic                      o_RegWriteW;
    logic                      o_MisalignW;
    logic [DATA_WIDTH-1:0]     o_HiW;
    logic [DATA_WIDTH-1:0]     o_LoW;
    logic [CNT_WIDTH-1:0]      o_RetireCount;

    modport master (
        output i_ValidM, i_RegWriteM, i_WriteRegM, i_ResultSrcM, i_HiLoSelM,
               i_LoadTypeM, i_LoadUnsignedM, i_HiLoWriteM, i_ALUOutM,
               i_ReadDataM, i_PCPlus4M, i_HiM, i_LoM, i_StallW, i_FlushW,
        input  o_ResultW, o_WriteRegW, o_RegWriteW, o_MisalignW,
               o_HiW, o_LoW, o_RetireCount
    );

    modport slave (
        input  i_ValidM, i_RegWriteM, i_WriteRegM, i_ResultSrcM, i_HiLoSelM,
               i_LoadTypeM, i_LoadUnsignedM, i_HiLoWriteM, i_ALUOutM,
               i_ReadDataM, i_PCPlus4M, i_HiM, i_LoM, i_StallW, i_FlushW,
        output o_ResultW, o_WriteRegW, o_RegWriteW, o_MisalignW,
               o_HiW, o_LoW, o_RetireCount
    );
endinterface

// File: rtl/wb_stage_pipelined.sv
// ----------------------------------------------------------------------------
// wb_stage_pipelined
//   MEM/WB pipeline register with stall/flush, load alignment with sign/zero
//   extension, four-way result select, architectural HI/LO and a retired
//   instruction counter.
//
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   wb      : wb_stage_pipelined_if.slave (M entry, stall/flush, W outputs)
//
//   All W outputs are combinational from the W register (one cycle after
//   capture). HI/LO and the counter update only when the W entry commits.
// ----------------------------------------------------------------------------
module wb_stage_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    wb_stage_pipelined_if.slave  wb
);
    localparam int OFF_W = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_LOAD = 2'b01,
        SRC_LINK = 2'b10,
        SRC_HILO = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        LD_FULL = 2'b00,
        LD_BYTE = 2'b01,
        LD_HALF = 2'b10,
        LD_RSVD = 2'b11
    } load_type_e;

    typedef struct packed {
        logic                      valid;
        logic                      reg_write;
        logic [REG_ADDR_WIDTH-1:0] write_reg;
        result_src_e               result_src;
        logic                      hilo_sel;
        load_type_e                load_type;
        logic                      load_unsigned;
        logic                      hilo_write;
        logic [DATA_WIDTH-1:0]     alu_out;
        logic [DATA_WIDTH-1:0]     read_data;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic [DATA_WIDTH-1:0]     hi;
        logic [DATA_WIDTH-1:0]     lo;
    } w_entry_t;

    w_entry_t              m_entry;
    w_entry_t              w_q;
    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [CNT_WIDTH-1:0]  retire_count_q;

    logic [OFF_W-1:0]      offset;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] result;
    logic                  misalign;
    logic                  commit;

    // NOTE: every signal written in an always_comb gets a default first, so
    //       no path through the block leaves it unassigned (no latch).
    always_comb begin
        m_entry               = '0;
        m_entry.valid         = wb.i_ValidM;
        m_entry.reg_write     = wb.i_RegWriteM;
        m_entry.write_reg     = wb.i_WriteRegM;
        m_entry.result_src    = result_src_e'(wb.i_ResultSrcM);
        m_entry.hilo_sel      = wb.i_HiLoSelM;
        m_entry.load_type     = load_type_e'(wb.i_LoadTypeM);
        m_entry.load_unsigned = wb.i_LoadUnsignedM;
        m_entry.hilo_write    = wb.i_HiLoWriteM;
        m_entry.alu_out       = wb.i_ALUOutM;
        m_entry.read_data     = wb.i_ReadDataM;
        m_entry.pc_plus4      = wb.i_PCPlus4M;
        m_entry.hi            = wb.i_HiM;
        m_entry.lo            = wb.i_LoM;
    end

    // W register. Flush wins over stall; a bubble is the all-zero entry.
    // NOTE: sequential state uses non-blocking assignments so every register
    //       samples pre-edge values regardless of block ordering. All fields
    //       are reset, not only valid, so every W output reads 0 in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_q <= '0;
        end else if (wb.i_FlushW) begin
            w_q <= '0;
        end else if (!wb.i_StallW) begin
            w_q <= m_entry;
        end
    end

    // Little-endian lane extraction from the low address bits.
    assign offset    = w_q.alu_out[OFF_W-1:0];
    assign byte_lane = 8'(w_q.read_data >> {offset, 3'b000});
    assign half_lane = 16'(w_q.read_data >> {offset[OFF_W-1:1], 4'b0000});

    always_comb begin
        load_ext = w_q.read_data;
        unique case (w_q.load_type)
            LD_BYTE: load_ext = w_q.load_unsigned
                              ? {{(DATA_WIDTH-8){1'b0}}, byte_lane}
                              : {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
            LD_HALF: load_ext = w_q.load_unsigned
                              ? {{(DATA_WIDTH-16){1'b0}}, half_lane}
                              : {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            default: load_ext = w_q.read_data;  // full width and reserved
        endcase
    end

    // Bytes are always aligned; halves need an even offset; full/reserved
    // loads need offset 0. Only real load entries can be misaligned.
    always_comb begin
        misalign = 1'b0;
        if (w_q.valid && w_q.result_src == SRC_LOAD) begin
            unique case (w_q.load_type)
                LD_BYTE: misalign = 1'b0;
                LD_HALF: misalign = offset[0];
                default: misalign = (offset != '0);
            endcase
        end
    end

    // HI/LO reads see the architectural value, i.e. before any update this
    // same entry is about to commit.
    always_comb begin
        result = w_q.alu_out;
        unique case (w_q.result_src)
            SRC_ALU:  result = w_q.alu_out;
            SRC_LOAD: result = load_ext;
            SRC_LINK: result = w_q.pc_plus4;
            SRC_HILO: result = w_q.hilo_sel ? hi_q : lo_q;
        endcase
    end

    // A held entry commits only on the edge where the stall releases; a
    // flush discards it without committing.
    assign commit = w_q.valid & ~wb.i_StallW & ~wb.i_FlushW & ~misalign;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_q           <= '0;
            lo_q           <= '0;
            retire_count_q <= '0;
        end else if (commit) begin
            retire_count_q <= retire_count_q + CNT_WIDTH'(1);
            if (w_q.hilo_write) begin
                hi_q <= w_q.hi;
                lo_q <= w_q.lo;
            end
        end
    end

    assign wb.o_ResultW     = result;
    assign wb.o_WriteRegW   = w_q.write_reg;
    assign wb.o_RegWriteW   = w_q.valid & w_q.reg_write & ~misalign;
    assign wb.o_MisalignW   = misalign;
    assign wb.o_HiW         = hi_q;
    assign wb.o_LoW         = lo_q;
    assign wb.o_RetireCount = retire_count_q;
endmodule

// File: tb/tb_wb_stage_pipelined.sv
// ----------------------------------------------------------------------------
// tb_wb_stage_pipelined
//   Scoreboard bench for wb_stage_pipelined. The driver applies one M entry
//   per cycle, advances a behavioural model of the stage and pushes the
//   expected W outputs into a queue; a separate monitor pops one expectation
//   per cycle and compares. A second instance with a 4-bit retire counter
//   shares the same stimulus so counter wrap-around is observed.
// ----------------------------------------------------------------------------
module tb_wb_stage_pipelined;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_stage_pipelined_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) bus_a ();
    wb_stage_pipelined_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4))  bus_b ();

    wb_stage_pipelined #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut_a (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .wb     (bus_a.slave)
    );

    wb_stage_pipelined #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut_b (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .wb     (bus_b.slave)
    );

    assign bus_b.i_ValidM        = bus_a.i_ValidM;
    assign bus_b.i_RegWriteM     = bus_a.i_RegWriteM;
    assign bus_b.i_WriteRegM     = bus_a.i_WriteRegM;
    assign bus_b.i_ResultSrcM    = bus_a.i_ResultSrcM;
    assign bus_b.i_HiLoSelM      = bus_a.i_HiLoSelM;
    assign bus_b.i_LoadTypeM     = bus_a.i_LoadTypeM;
    assign bus_b.i_LoadUnsignedM = bus_a.i_LoadUnsignedM;
    assign bus_b.i_HiLoWriteM    = bus_a.i_HiLoWriteM;
    assign bus_b.i_ALUOutM       = bus_a.i_ALUOutM;
    assign bus_b.i_ReadDataM     = bus_a.i_ReadDataM;
    assign bus_b.i_PCPlus4M      = bus_a.i_PCPlus4M;
    assign bus_b.i_HiM           = bus_a.i_HiM;
    assign bus_b.i_LoM           = bus_a.i_LoM;
    assign bus_b.i_StallW        = bus_a.i_StallW;
    assign bus_b.i_FlushW        = bus_a.i_FlushW;

    typedef struct packed {
        bit        valid;
        bit        reg_write;
        bit [4:0]  write_reg;
        bit [1:0]  src;
        bit        hilo_sel;
        bit [1:0]  load_type;
        bit        load_unsigned;
        bit        hilo_write;
        bit [31:0] alu;
        bit [31:0] rd;
        bit [31:0] pc4;
        bit [31:0] hi;
        bit [31:0] lo;
    } entry_t;

    typedef struct packed {
        bit [31:0] result;
        bit [4:0]  write_reg;
        bit        reg_write;
        bit        misalign;
        bit [31:0] hi;
        bit [31:0] lo;
        bit [31:0] cnt;
    } exp_t;

    exp_t      exp_q[$];
    int        n_compared = 0;
    int        n_failed   = 0;

    // Model state: the entry currently sitting in W plus architectural state.
    entry_t    mw;
    bit [31:0] mhi, mlo, mcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_misaligned(input entry_t e);
        int unsigned off;
        off = e.alu % 4;
        if (!e.valid || e.src != 2'b01) return 1'b0;
        if (e.load_type == 2'b01) return 1'b0;
        if (e.load_type == 2'b10) return (off % 2) != 0;
        return off != 0;
    endfunction

    function automatic bit [31:0] load_value(input entry_t e);
        int unsigned off;
        bit [31:0]   v;
        off = e.alu % 4;
        case (e.load_type)
            2'b01: begin
                v = (e.rd >> (8 * off)) & 32'h0000_00FF;
                if (!e.load_unsigned && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            2'b10: begin
                v = (e.rd >> (16 * (off / 2))) & 32'h0000_FFFF;
                if (!e.load_unsigned && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = e.rd;
        endcase
        return v;
    endfunction

    function automatic exp_t outputs_of(input entry_t w, input bit [31:0] hi, input bit [31:0] lo,
                                        input bit [31:0] cnt);
        exp_t x;
        bit   mis;
        mis = is_misaligned(w);
        case (w.src)
            2'b00:   x.result = w.alu;
            2'b01:   x.result = load_value(w);
            2'b10:   x.result = w.pc4;
            default: x.result = w.hilo_sel ? hi : lo;
        endcase
        x.write_reg = w.write_reg;
        x.reg_write = w.valid && w.reg_write && !mis;
        x.misalign  = mis;
        x.hi        = hi;
        x.lo        = lo;
        x.cnt       = cnt;
        return x;
    endfunction

    // One clock edge of the stage, in terms of the architectural rules.
    task automatic model_step(input entry_t m, input bit stall, input bit flush);
        if (mw.valid && !stall && !flush && !is_misaligned(mw)) begin
            mcnt = mcnt + 1;
            if (mw.hilo_write) begin
                mhi = mw.hi;
                mlo = mw.lo;
            end
        end
        if (flush)       mw = '0;
        else if (!stall) mw = m;
    endtask

    task automatic apply(input entry_t m, input bit stall, input bit flush);
        bus_a.i_ValidM        = m.valid;
        bus_a.i_RegWriteM     = m.reg_write;
        bus_a.i_WriteRegM     = m.write_reg;
        bus_a.i_ResultSrcM    = m.src;
        bus_a.i_HiLoSelM      = m.hilo_sel;
        bus_a.i_LoadTypeM     = m.load_type;
        bus_a.i_LoadUnsignedM = m.load_unsigned;
        bus_a.i_HiLoWriteM    = m.hilo_write;
        bus_a.i_ALUOutM       = m.alu;
        bus_a.i_ReadDataM     = m.rd;
        bus_a.i_PCPlus4M      = m.pc4;
        bus_a.i_HiM           = m.hi;
        bus_a.i_LoM           = m.lo;
        bus_a.i_StallW        = stall;
        bus_a.i_FlushW        = flush;
    endtask

    // Called at a falling edge: drives one entry, predicts the outputs after
    // the next rising edge, and returns at the following falling edge.
    task automatic drive(input entry_t m, input bit stall, input bit flush);
        apply(m, stall, flush);
        model_step(m, stall, flush);
        exp_q.push_back(outputs_of(mw, mhi, mlo, mcnt));
        @(negedge clk);
    endtask

    function automatic entry_t random_entry();
        entry_t e;
        e.valid         = ($urandom % 10) < 8;
        e.reg_write     = 1'($urandom);
        e.write_reg     = 5'($urandom);
        e.src           = 2'($urandom);
        e.hilo_sel      = 1'($urandom);
        e.load_type     = 2'($urandom);
        e.load_unsigned = 1'($urandom);
        e.hilo_write    = ($urandom % 4) == 0;
        e.alu           = $urandom;
        e.rd            = $urandom;
        e.pc4           = $urandom;
        e.hi            = $urandom;
        e.lo            = $urandom;
        return e;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_result"},    bus_a.o_ResultW, 32'h0);
        check({tag, "_write_reg"}, 32'(bus_a.o_WriteRegW), 32'h0);
        check({tag, "_reg_write"}, 32'(bus_a.o_RegWriteW), 32'h0);
        check({tag, "_misalign"},  32'(bus_a.o_MisalignW), 32'h0);
        check({tag, "_hi"},        bus_a.o_HiW, 32'h0);
        check({tag, "_lo"},        bus_a.o_LoW, 32'h0);
        check({tag, "_count"},     bus_a.o_RetireCount, 32'h0);
        check({tag, "_count4"},    32'(bus_b.o_RetireCount), 32'h0);
    endtask

    task automatic model_reset();
        mw   = '0;
        mhi  = '0;
        mlo  = '0;
        mcnt = '0;
    endtask

    // Asserts reset between clock edges and checks the outputs clear before
    // any edge arrives. Starts and ends at a falling edge.
    task automatic async_reset();
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        apply('0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one expectation per clock while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_result",    bus_a.o_ResultW, e.result);
                check("sb_write_reg", 32'(bus_a.o_WriteRegW), 32'(e.write_reg));
                check("sb_reg_write", 32'(bus_a.o_RegWriteW), 32'(e.reg_write));
                check("sb_misalign",  32'(bus_a.o_MisalignW), 32'(e.misalign));
                check("sb_hi",        bus_a.o_HiW, e.hi);
                check("sb_lo",        bus_a.o_LoW, e.lo);
                check("sb_count",     bus_a.o_RetireCount, e.cnt);
                check("sb_count4",    32'(bus_b.o_RetireCount), 32'(e.cnt[3:0]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        entry_t    e;
        bit [31:0] cnt_before;
        int        budget;

        rst_n = 1'b0;
        model_reset();
        apply('0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("reset");
        repeat (2) drive('0, 1'b0, 1'b0);

        // Byte loads from 0x80FF_7F01.
        e = '0;
        e.valid = 1'b1; e.reg_write = 1'b1; e.write_reg = 5'd3;
        e.src = 2'b01; e.load_type = 2'b01; e.rd = 32'h80FF_7F01;
        e.alu = 32'h1000_0001;
        drive(e, 1'b0, 1'b0);
        check("byte_signed_off1", bus_a.o_ResultW, 32'h0000_007F);
        e.alu = 32'h1000_0003;
        drive(e, 1'b0, 1'b0);
        check("byte_signed_off3", bus_a.o_ResultW, 32'hFFFF_FF80);
        e.load_unsigned = 1'b1;
        drive(e, 1'b0, 1'b0);
        check("byte_unsigned_off3", bus_a.o_ResultW, 32'h0000_0080);

        // Half loads: aligned at offset 2, then misaligned at offset 1.
        e.load_type = 2'b10; e.load_unsigned = 1'b0;
        e.rd = 32'h8001_1234; e.alu = 32'h1000_0002;
        drive(e, 1'b0, 1'b0);
        check("half_signed_off2", bus_a.o_ResultW, 32'hFFFF_8001);
        e.alu = 32'h1000_0001;
        drive(e, 1'b0, 1'b0);
        check("half_misalign_flag", 32'(bus_a.o_MisalignW), 32'h1);
        check("half_misalign_nowrite", 32'(bus_a.o_RegWriteW), 32'h0);
        cnt_before = mcnt;
        drive('0, 1'b0, 1'b0);
        check("half_misalign_nocommit", bus_a.o_RetireCount, cnt_before);

        // HI/LO write followed by mflo / mfhi.
        e = '0;
        e.valid = 1'b1; e.hilo_write = 1'b1; e.hi = 32'h1; e.lo = 32'h2;
        drive(e, 1'b0, 1'b0);
        e = '0;
        e.valid = 1'b1; e.reg_write = 1'b1; e.write_reg = 5'd8; e.src = 2'b11;
        drive(e, 1'b0, 1'b0);
        check("mflo_result", bus_a.o_ResultW, 32'h2);
        e.hilo_sel = 1'b1;
        drive(e, 1'b0, 1'b0);
        check("mfhi_result", bus_a.o_ResultW, 32'h1);

        // Three-cycle stall on a valid ALU entry.
        e = '0;
        e.valid = 1'b1; e.reg_write = 1'b1; e.write_reg = 5'd9; e.alu = 32'h55;
        drive(e, 1'b0, 1'b0);
        cnt_before = mcnt;
        for (int i = 0; i < 3; i++) begin
            entry_t r;
            r = random_entry();
            r.hilo_write = 1'b0;
            drive(r, 1'b1, 1'b0);
            check("stall_result", bus_a.o_ResultW, 32'h55);
            check("stall_reg_write", 32'(bus_a.o_RegWriteW), 32'h1);
            check("stall_count_held", bus_a.o_RetireCount, cnt_before);
        end
        drive('0, 1'b0, 1'b0);
        check("stall_release_commit", bus_a.o_RetireCount, cnt_before + 32'd1);

        // Stall and flush together on a held HI/LO-writing entry.
        e = '0;
        e.valid = 1'b1; e.hilo_write = 1'b1; e.hi = 32'hAAAA; e.lo = 32'hBBBB;
        drive(e, 1'b0, 1'b0);
        cnt_before = mcnt;
        drive('0, 1'b1, 1'b1);
        check("stallflush_reg_write", 32'(bus_a.o_RegWriteW), 32'h0);
        check("stallflush_result", bus_a.o_ResultW, 32'h0);
        drive('0, 1'b0, 1'b0);
        check("stallflush_hi", bus_a.o_HiW, 32'h1);
        check("stallflush_lo", bus_a.o_LoW, 32'h2);
        check("stallflush_count", bus_a.o_RetireCount, cnt_before);

        // Mid-stream asynchronous reset with non-zero state.
        async_reset();

        // Exactly 16 commits after reset: the 4-bit counter wraps to 0.
        for (int i = 0; i < 16; i++) begin
            e = '0;
            e.valid = 1'b1; e.alu = 32'(i);
            drive(e, 1'b0, 1'b0);
        end
        drive('0, 1'b0, 1'b0);
        check("wrap_count4", 32'(bus_b.o_RetireCount), 32'h0);
        check("wrap_count32", bus_a.o_RetireCount, 32'd16);

        // Randomised traffic with stalls and flushes.
        for (int i = 0; i < 400; i++) begin
            drive(random_entry(), ($urandom % 5) == 0, ($urandom % 10) == 0);
        end
        drive('0, 1'b0, 1'b0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule
